// File: rtl/alu_share_arb.sv
// Two-port arbiter in front of one shared ALU: picks a requester, holds its
// operands on the ALU for one cycle, registers result/flags and returns them.
module alu_share_arb #(
    parameter int WIDTH     = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_gin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zout,
    input  logic             alu_vout,
    input  logic             alu_nout,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n,
    output logic             rsp_err,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic             grant;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             win;
    logic             any_req;
    logic             legal;
    logic             v_ok;
    logic             rsp_take;

    // win: 0 -> port 0, 1 -> port 1; only meaningful when any_req
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            win = (FIXED_PRI != 0) ? 1'b0 : ~last_grant;
        else
            win = ~req0_valid;
    end

    assign req0_ready = (state == IDLE) & req0_valid & ~win;
    assign req1_ready = (state == IDLE) & req1_valid & win;

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_gin = op_q;

    assign legal    = (op_q != 3'b100) && (op_q != 3'b101);
    // the ALU only refreshes its overflow output for add and subtract
    assign v_ok     = (op_q == 3'b010) || (op_q == 3'b110);
    assign rsp_take = grant ? rsp1_ready : rsp0_ready;

    assign rsp0_valid = (state == RESP) & ~grant;
    assign rsp1_valid = (state == RESP) & grant;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    a_q        <= win ? req1_a  : req0_a;
                    b_q        <= win ? req1_b  : req0_b;
                    op_q       <= win ? req1_op : req0_op;
                    grant      <= win;
                    last_grant <= win;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_result <= legal ? alu_result : '0;
                    rsp_z      <= legal & alu_zout;
                    rsp_n      <= legal & alu_nout;
                    rsp_v      <= legal & v_ok & alu_vout;
                    rsp_err    <= ~legal;
                    state      <= RESP;
                end
                RESP: if (rsp_take) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
